// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, in-order imem requests, prefetch FIFO, redirect flush
// Optional build macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect targets are trapped instead of truncated).
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misaligned
);
    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = AW + 1;
    localparam int          DW  = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_word [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [DW-1:0] r_drop;
    logic [31:0]   r_pcq [DEPTH];
    logic [AW-1:0] r_pcq_rd;
    logic [AW-1:0] r_pcq_wr;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_room;
    logic          w_inhibit;
    logic          w_redir_bad;
    logic [31:0]   w_redir_pc;
    logic [CW:0]   w_inflight;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misaligned;

    assign w_redir_bad = (redirect_pc[1:0] != 2'b00);
    assign w_redir_pc  = redirect_pc;
    assign w_inhibit   = r_misaligned;
    assign misaligned  = r_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (redirect_valid && w_redir_bad) begin
            r_misaligned <= 1'b1;
        end
    end
`else
    assign w_redir_bad = 1'b0;
    assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign w_inhibit   = 1'b0;
    assign misaligned  = 1'b0;
`endif

    // Buffered plus in-flight words never exceed DEPTH, so a response always finds a free slot.
    assign w_inflight     = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_room         = (w_inflight < (CW+1)'(DEPTH));
    assign imem_req_valid = rst_n && !halt && !redirect_valid && !w_inhibit && w_room;
    assign imem_req_addr  = r_fetch_pc;

    assign w_accept = imem_req_valid && imem_req_ready;
    assign w_push   = imem_rsp_valid && (r_drop == '0);
    assign w_pop    = instr_valid && instr_ready;

    assign instr_valid = (r_count != '0);
    assign instr       = r_fifo_word[r_rd_ptr];
    assign instr_pc    = r_fifo_pc[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_pcq_rd      <= '0;
            r_pcq_wr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]   <= RESET_PC;
                r_fifo_word[i] <= NOP;
                r_pcq[i]       <= RESET_PC;
            end
        end else if (redirect_valid) begin
            // Every outstanding request not answered this cycle becomes a response to discard.
            r_drop        <= r_drop + DW'(r_outstanding) - DW'(imem_rsp_valid);
            r_outstanding <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_pcq_rd      <= '0;
            r_pcq_wr      <= '0;
            if (!w_redir_bad) begin
                r_fetch_pc <= w_redir_pc;
            end
        end else begin
            if (w_accept) begin
                r_pcq[r_pcq_wr] <= r_fetch_pc;
                r_pcq_wr        <= r_pcq_wr + AW'(1);
                r_fetch_pc      <= r_fetch_pc + 32'd4;
            end
            if (imem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - DW'(1);
            end
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]   <= r_pcq[r_pcq_rd];
                r_fifo_word[r_wr_ptr] <= imem_rsp_data;
                r_wr_ptr              <= r_wr_ptr + AW'(1);
                r_pcq_rd              <= r_pcq_rd + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_push);
        end
    end
endmodule
